// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared pipeline definitions used by the pipeline control slice.
//   - pipe_state_t : control FSM state encoding (RUN / STALL / FLUSH / TRAP)
//   - MAX_INFLIGHT_DEF : default limit on issued-but-not-written-back instrs
//   - REG_IDX_W / NUM_REGS : register index width and register file size
//   - INFLIGHT_W : width of the inflight counter (holds 0..15)
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_TRAP  = 2'd3
    } pipe_state_t;

    localparam int MAX_INFLIGHT_DEF = 4;
    localparam int REG_IDX_W        = 5;
    localparam int NUM_REGS         = 32;
    localparam int INFLIGHT_W       = 4;

endpackage

// File: rtl/pipe_scoreboard.sv
// ----------------------------------------------------------------------------
// pipe_scoreboard
//   Register scoreboard: one busy bit per architectural register plus a count
//   of instructions issued but not yet written back.
//   Ports:
//     clk, resetn        clock, asynchronous active-low reset
//     set_en, set_rd     an instruction writing set_rd issues this cycle
//     clr_en, clr_rd     writeback retires a write to clr_rd this cycle
//     issue_en           any instruction issues (counts toward inflight)
//     busy[31:0]         bit n = write to xn outstanding (bit 0 always 0)
//     inflight           issued-but-not-written-back count
// ----------------------------------------------------------------------------
module pipe_scoreboard
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  issue_en,
    input  logic                  set_en,
    input  logic [REG_IDX_W-1:0]  set_rd,
    input  logic                  clr_en,
    input  logic [REG_IDX_W-1:0]  clr_rd,
    output logic [NUM_REGS-1:0]   busy,
    output logic [INFLIGHT_W-1:0] inflight
);

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_next;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic [INFLIGHT_W-1:0] inflight_next;
    logic                  dec;

    // Clear is applied before set, so a same-cycle writeback and re-issue of
    // the same register leaves the bit set for the newer instruction.
    always_comb begin
        busy_next = busy_q;
        if (clr_en) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // A writeback with nothing outstanding is a protocol error; the counter
    // saturates at zero rather than wrapping.
    assign dec = clr_en && (inflight_q != '0);

    always_comb begin
        inflight_next = inflight_q;
        case ({issue_en, dec})
            2'b10:   inflight_next = inflight_q + 1'b1;
            2'b01:   inflight_next = inflight_q - 1'b1;
            default: inflight_next = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q     <= '0;
            inflight_q <= '0;
        end else begin
            busy_q     <= busy_next;
            inflight_q <= inflight_next;
        end
    end

    assign busy     = busy_q;
    assign inflight = inflight_q;

    a_wb_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(clr_en && (inflight_q == '0)));

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//   In-order pipeline control: data/structural hazard detection against the
//   register scoreboard, issue, stall, flush on redirect, and the illegal
//   instruction trap handshake.
//
//   Handshake: decode offers an instruction with id_valid; it is consumed in
//   the cycle issue = 1. While id_valid = 1 and issue = 0, decode holds the
//   instruction (stall_id) unless the cycle flushes it. ex_ready is execute's
//   ready; issue never asserts without it.
//
//   Ports:
//     clk, resetn                       clock, asynchronous active-low reset
//     id_valid, id_rs1/2, id_use_rs1/2  decode instruction and source use
//     id_rd, id_reg_write, id_illegal   destination and illegal flag
//     ex_ready                          execute accepts this cycle
//     redirect, redirect_pc             taken branch/jump and its target
//     wb_valid, wb_rd                   writeback retiring a register write
//     trap_ack                          trap handler acknowledge
//     issue, stall_if, stall_id         issue / hold fetch and decode
//     flush_if, flush_id                squash fetch and decode
//     pc_load, pc_next                  load fetch PC
//     trap                              illegal-instruction trap pending
//     busy                              scoreboard vector
//     state_dbg, inflight_dbg           FSM state and inflight count
// ----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  id_valid,
    input  logic [REG_IDX_W-1:0]  id_rs1,
    input  logic [REG_IDX_W-1:0]  id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_IDX_W-1:0]  id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_illegal,
    input  logic                  ex_ready,
    input  logic                  redirect,
    input  logic [63:0]           redirect_pc,
    input  logic                  wb_valid,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic                  trap_ack,
    output logic                  issue,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  pc_load,
    output logic [63:0]           pc_next,
    output logic                  trap,
    output logic [NUM_REGS-1:0]   busy,
    output pipe_state_t           state_dbg,
    output logic [INFLIGHT_W-1:0] inflight_dbg
);

    pipe_state_t           state;
    pipe_state_t           next_state;
    logic [INFLIGHT_W-1:0] inflight;
    logic                  hazard;
    logic                  redir;
    logic                  issue_c;
    logic                  stall_c;
    logic                  flush_if_c;
    logic                  flush_id_c;
    logic                  pc_load_c;

    // busy[0] is held at zero by the scoreboard, so x0 never hazards.
    assign hazard = id_valid && (
                       (id_use_rs1   && busy[id_rs1]) ||
                       (id_use_rs2   && busy[id_rs2]) ||
                       (id_reg_write && busy[id_rd])  ||
                       (inflight == INFLIGHT_W'(MAX_INFLIGHT)) ||
                       !ex_ready);

    // A trap cannot be interrupted by a redirect; it only leaves via trap_ack.
    assign redir = redirect && (state != ST_TRAP);

    always_comb begin
        next_state = state;
        issue_c    = 1'b0;
        stall_c    = 1'b0;
        flush_if_c = 1'b0;
        flush_id_c = 1'b0;
        pc_load_c  = 1'b0;
        case (state)
            ST_RUN, ST_STALL: begin
                if (redir) begin
                    pc_load_c  = 1'b1;
                    flush_if_c = 1'b1;
                    flush_id_c = 1'b1;
                    next_state = ST_FLUSH;
                end else if (id_valid && id_illegal) begin
                    stall_c    = 1'b1;
                    next_state = ST_TRAP;
                end else if (hazard) begin
                    stall_c    = 1'b1;
                    next_state = ST_STALL;
                end else begin
                    issue_c    = id_valid;
                    next_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_id_c = 1'b1;
                if (redir) begin
                    pc_load_c  = 1'b1;
                    flush_if_c = 1'b1;
                    next_state = ST_FLUSH;
                end else begin
                    next_state = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    flush_if_c = 1'b1;
                    flush_id_c = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    stall_c    = 1'b1;
                end
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // The control outputs are same-cycle functions of decode/execute inputs;
    // gating with resetn keeps them quiet while reset is held.
    assign issue    = resetn && issue_c;
    assign stall_if = resetn && stall_c;
    assign stall_id = resetn && stall_c;
    assign flush_if = resetn && flush_if_c;
    assign flush_id = resetn && flush_id_c;
    assign pc_load  = resetn && pc_load_c;
    assign pc_next  = pc_load ? redirect_pc : '0;
    assign trap     = (state == ST_TRAP);

    pipe_scoreboard u_sb (
        .clk      (clk),
        .resetn   (resetn),
        .issue_en (issue),
        .set_en   (issue && id_reg_write),
        .set_rd   (id_rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .busy     (busy),
        .inflight (inflight)
    );

    assign state_dbg    = state;
    assign inflight_dbg = inflight;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl: data hazard stall/release, inflight limit,
//   same-register issue/writeback, x0 handling, ex_ready back-pressure,
//   redirect from STALL and from FLUSH, illegal-instruction trap, and reset
//   in mid-operation.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic        issue;
        logic        stall_if;
        logic        stall_id;
        logic        flush_if;
        logic        flush_id;
        logic        pc_load;
        logic        trap;
        logic [63:0] pc_next;
    } outs_t;

    localparam int OUTS_W = $bits(outs_t);

    // ---------------- clock / reset ----------------
    logic clk;
    logic resetn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                  id_valid;
    logic [4:0]            id_rs1, id_rs2, id_rd, wb_rd;
    logic                  id_use_rs1, id_use_rs2, id_reg_write, id_illegal;
    logic                  ex_ready, redirect, wb_valid, trap_ack;
    logic [63:0]           redirect_pc;
    logic                  issue, stall_if, stall_id, flush_if, flush_id;
    logic                  pc_load, trap;
    logic [63:0]           pc_next;
    logic [31:0]           busy;
    pipe_state_t           state_dbg;
    logic [INFLIGHT_W-1:0] inflight_dbg;

    pipe_ctrl #(.MAX_INFLIGHT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_illegal   (id_illegal),
        .ex_ready     (ex_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .trap_ack     (trap_ack),
        .issue        (issue),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .pc_load      (pc_load),
        .pc_next      (pc_next),
        .trap         (trap),
        .busy         (busy),
        .state_dbg    (state_dbg),
        .inflight_dbg (inflight_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [OUTS_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic outs_t mk(input logic iss, input logic stl, input logic fif,
                                 input logic fid, input logic pcl,
                                 input logic [63:0] pcn, input logic trp);
        outs_t o;
        o.issue    = iss;
        o.stall_if = stl;
        o.stall_id = stl;
        o.flush_if = fif;
        o.flush_id = fid;
        o.pc_load  = pcl;
        o.trap     = trp;
        o.pc_next  = pcn;
        return o;
    endfunction

    // Push the expectation when stimulus is applied, pop it when the DUT's
    // combinational outputs have settled.
    task automatic sample(input string tag, input outs_t e, input int dly);
        outs_t obs;
        logic [OUTS_W-1:0] exp_v;
        exp_q.push_back(e);
        #(dly);
        obs.issue    = issue;
        obs.stall_if = stall_if;
        obs.stall_id = stall_id;
        obs.flush_if = flush_if;
        obs.flush_id = flush_id;
        obs.pc_load  = pc_load;
        obs.trap     = trap;
        obs.pc_next  = pc_next;
        exp_v = exp_q.pop_front();
        chk(tag, 128'(obs), 128'(exp_v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        redirect = 1'b0;
        trap_ack = 1'b0;
    endtask

    task automatic step(input string tag, input outs_t e);
        sample(tag, e, 2);
        tick();
    endtask

    task automatic post(input string tag, input logic [31:0] b, input int infl,
                        input pipe_state_t st);
        chk({tag, "_busy"}, 128'(busy), 128'(b));
        chk({tag, "_inflight"}, 128'(inflight_dbg), 128'(infl));
        chk({tag, "_state"}, 128'(state_dbg), 128'(st));
    endtask

    // ---------------- drivers ----------------
    task automatic drv_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic ill);
        id_valid     = v;
        id_rs1       = rs1;
        id_use_rs1   = u1;
        id_rs2       = rs2;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_illegal   = ill;
    endtask

    task automatic drv_wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    task automatic drv_redir(input logic [63:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
    endtask

    task automatic idle_id();
        drv_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    outs_t o_idle, o_iss, o_stl;

    initial begin
        o_idle = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        o_iss  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        o_stl  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        o_stl.stall_id = 1'b1;

        resetn      = 1'b0;
        idle_id();
        ex_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        trap_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample("reset_outs", o_idle, 2);
        post("reset", 32'h0, 0, ST_RUN);
        resetn = 1'b1;
        tick();

        // RAW hazard on x5
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step("raw_issue_x5", o_iss);
        post("raw_issue_x5", 32'h0000_0020, 1, ST_RUN);
        drv_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        step("raw_stall_1", o_stl);
        post("raw_stall_1", 32'h0000_0020, 1, ST_STALL);
        step("raw_stall_2", o_stl);
        drv_wb(5'd5);
        step("raw_stall_wb", o_stl);
        post("raw_stall_wb", 32'h0, 0, ST_STALL);
        step("raw_release", o_iss);
        post("raw_release", 32'h0000_0040, 1, ST_RUN);
        idle_id();
        drv_wb(5'd6);
        step("raw_drain", o_idle);
        post("raw_drain", 32'h0, 0, ST_RUN);

        // inflight limit
        for (int i = 1; i <= 4; i++) begin
            drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0);
            step("limit_issue", o_iss);
        end
        post("limit_fill", 32'h0000_001E, 4, ST_RUN);
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        step("limit_stall", o_stl);
        post("limit_stall", 32'h0000_001E, 4, ST_STALL);
        drv_wb(5'd1);
        step("limit_stall_wb", o_stl);
        post("limit_stall_wb", 32'h0000_001C, 3, ST_STALL);
        step("limit_resume", o_iss);
        post("limit_resume", 32'h0000_011C, 4, ST_RUN);

        // same-cycle issue and writeback of x7, then x0 destination
        idle_id();
        drv_wb(5'd2);
        step("same_pre_wb", o_idle);
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        drv_wb(5'd7);
        step("same_issue_wb", o_iss);
        post("same_issue_wb", 32'h0000_0198, 3, ST_RUN);
        drv_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        step("x0_issue", o_iss);
        post("x0_issue", 32'h0000_0198, 4, ST_RUN);
        idle_id();
        drv_wb(5'd3); step("drain_3", o_idle);
        drv_wb(5'd4); step("drain_4", o_idle);
        drv_wb(5'd7); step("drain_7", o_idle);
        drv_wb(5'd8); step("drain_8", o_idle);
        post("drain", 32'h0, 0, ST_RUN);

        // ex_ready back-pressure
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        ex_ready = 1'b0;
        step("exrdy_stall", o_stl);
        ex_ready = 1'b1;
        step("exrdy_issue", o_iss);
        post("exrdy_issue", 32'h0000_0200, 1, ST_RUN);

        // redirect from STALL, then redirect during FLUSH
        drv_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("redir_stall", o_stl);
        drv_redir(64'h0000_0000_8000_0040);
        step("redir_from_stall", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0040, 1'b0));
        post("redir_from_stall", 32'h0000_0200, 1, ST_FLUSH);
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("flush_cycle", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0));
        post("flush_cycle", 32'h0000_0200, 1, ST_RUN);
        idle_id();
        drv_redir(64'h100);
        step("redir_run", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h100, 1'b0));
        drv_redir(64'h200);
        step("redir_in_flush", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h200, 1'b0));
        post("redir_in_flush", 32'h0000_0200, 1, ST_FLUSH);
        drv_wb(5'd9);
        step("flush_wb", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0));
        post("flush_wb", 32'h0, 0, ST_RUN);

        // illegal-instruction trap
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        step("trap_pre_issue", o_iss);
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        step("trap_enter", o_stl);
        post("trap_enter", 32'h0000_0400, 1, ST_TRAP);
        o_stl.trap = 1'b1;
        step("trap_hold_1", o_stl);
        drv_wb(5'd10);
        step("trap_hold_wb", o_stl);
        post("trap_hold_wb", 32'h0, 0, ST_TRAP);
        drv_redir(64'h300);
        step("trap_hold_redir", o_stl);
        o_stl.trap = 1'b0;
        idle_id();
        trap_ack = 1'b1;
        step("trap_ack", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1));
        post("trap_ack", 32'h0, 0, ST_RUN);
        step("trap_after", o_idle);

        // reset in mid-operation
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step("rst_issue_5", o_iss);
        drv_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        step("rst_issue_7", o_iss);
        drv_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("rst_stall", o_stl);
        post("rst_pre", 32'h0000_00A0, 2, ST_STALL);
        drv_redir(64'h0000_0000_8000_0040);
        sample("rst_pre_redir", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0040, 1'b0), 2);
        resetn = 1'b0;
        sample("rst_async_outs", o_idle, 1);
        post("rst_async", 32'h0, 0, ST_RUN);
        idle_id();
        tick();
        resetn = 1'b1;
        step("rst_release", o_idle);
        post("rst_release", 32'h0, 0, ST_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MAX_INFLIGHT, default 4: maximum issued-but-not-written-back instructions, legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  decode holds a valid instruction.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices from decode.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  the instruction reads rs1/rs2.
REQ-007 id_rd  in  5, id_reg_write  in  1  destination index and write-enable from decode.
REQ-008 id_illegal  in  1  decode flags an unsupported encoding.
REQ-009 ex_ready  in  1  execute stage accepts an instruction this cycle.
REQ-010 redirect  in  1  execute resolved a taken branch or jump; redirect_pc  in  64  target.
REQ-011 wb_valid  in  1, wb_rd  in  5  writeback retires a register write.
REQ-012 trap_ack  in  1  trap handler acknowledges an illegal-instruction trap.
REQ-013 issue  out  1  decode instruction is handed to execute this cycle.
REQ-014 stall_if, stall_id  out  1 each  hold fetch / decode registers.
REQ-015 flush_if, flush_id  out  1 each  squash fetch / decode contents.
REQ-016 pc_load  out  1, pc_next  out  64  load fetch PC with pc_next.
REQ-017 trap  out  1  illegal-instruction trap pending.
REQ-018 busy  out  32  scoreboard vector; bit n = write to xn outstanding.

Function
REQ-019 FSM states RUN, STALL, FLUSH, TRAP; encoding is a shared enum.
REQ-020 Hazard (combinational) = id_valid AND (rs1 busy & id_use_rs1, OR rs2 busy & id_use_rs2, OR rd busy & id_reg_write, OR inflight == MAX_INFLIGHT, OR ex_ready == 0).
REQ-021 issue = id_valid AND no hazard AND state in {RUN, STALL} AND redirect == 0 AND id_illegal == 0.
REQ-022 On issue with id_reg_write and id_rd != 0: set busy[id_rd] at the next edge; inflight increments on every issue.
REQ-023 On wb_valid: clear busy[wb_rd] (wb_rd == 0 has no effect) and decrement inflight.
REQ-024 Same-cycle issue and writeback to the same register: clear applies first, then set; busy bit ends set and inflight is unchanged.
REQ-025 busy[0] is constant 0; an id_rs of 0 never produces a hazard.
REQ-026 Writeback while inflight == 0 is a protocol error; inflight saturates at 0 and the simulation assertion fires.
REQ-027 RUN -> STALL when a hazard blocks a valid instruction; STALL -> RUN in the cycle the hazard clears (issue asserts in that same cycle).
REQ-028 stall_if = stall_id = 1 whenever id_valid and issue == 0, except in FLUSH and on redirect.
REQ-029 redirect (any state except TRAP) takes priority: pc_load = 1, pc_next = redirect_pc, flush_if = flush_id = 1 in the same cycle, issue = 0; next state FLUSH.
REQ-030 FLUSH lasts exactly one cycle: flush_id = 1, issue = 0; then RUN. A redirect during FLUSH restarts FLUSH with the new target.
REQ-031 id_illegal with id_valid in RUN/STALL and no redirect: enter TRAP; trap = 1, stall_if = stall_id = 1 until trap_ack; then flush_if = flush_id = 1 for one cycle and return to RUN.
REQ-032 Writebacks continue to update busy/inflight in every state, including TRAP and FLUSH.
REQ-033 issue latency: zero cycles from the hazard-free id_valid; busy update is visible one cycle after issue.

Reset
REQ-034 resetn low asynchronously forces: state RUN, busy = 0, inflight = 0, issue = 0, stalls = 0, flushes = 0, pc_load = 0, pc_next = 0, trap = 0.
REQ-035 Reset mid-operation discards all outstanding scoreboard entries; writebacks after reset release still decrement inflight only if it is nonzero (REQ-026).

Structure
REQ-036 The FSM state enum, MAX_INFLIGHT default, and register-index width constant belong in the shared pipeline package.
REQ-037 The scoreboard (busy vector and inflight counter) SHALL be one sub-module, pipe_scoreboard; the FSM and output logic stay in pipe_ctrl.

Verification
REQ-038 Issue x5 write, next cycle decode reads x5 -> stall_id = 1 until wb_valid/wb_rd = 5, then issue = 1 in the following cycle.
REQ-039 Issue 4 non-dependent writes with no writeback -> 5th valid instruction stalls; one writeback -> issue resumes next cycle.
REQ-040 redirect with redirect_pc = 0x8000_0040 while STALL -> pc_load = 1, pc_next = 0x8000_0040, flush_if/flush_id = 1, one FLUSH cycle, then RUN.
REQ-041 Same-cycle issue(rd = 7) and wb(rd = 7) -> busy[7] = 1, inflight unchanged.
REQ-042 id_illegal = 1 -> trap = 1 and stalls held for 3 cycles; trap_ack -> one flush cycle, RUN.
REQ-043 Assert resetn low with busy = 0x0000_00A0 and inflight = 2 -> all outputs zero immediately, busy = 0.
